xadac_issue_ctrl: RTL

- Initiator (master) end of the xadac request/response protocol.
- Accepts offload commands from the core-side decode stage and issues them in order to one xadac execution unit (e.g. vbias).
- Tracks outstanding requests with a credit counter and an issued-ID FIFO, checks response IDs, and buffers responses toward the writeback side.
- Sits between the CVA6 offload decoder and any xadac_if slave unit.

---
 rtl/xadac_pkg.sv | 22 ++
 rtl/xadac_if.sv | 25 ++
 rtl/xadac_fifo.sv | 69 ++++++
 rtl/xadac_issue_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/xadac_pkg.sv
// Shared widths and types for the xadac offload request/response path.
package xadac_pkg;

    localparam int unsigned IdWidth   = 5;
    localparam int unsigned RegWidth  = 32;
    localparam int unsigned ImmWidth  = 3;
    localparam int unsigned NrLanes   = 4;
    localparam int unsigned ElemWidth = 32;

    typedef logic [IdWidth-1:0]   IdT;
    typedef logic [RegWidth-1:0]  RegT;
    typedef logic [ImmWidth-1:0]  ImmT;
    typedef logic [ElemWidth-1:0] SumT;
    typedef SumT [NrLanes-1:0]    VecT;

    typedef struct packed {
        IdT  id;
        RegT rd;
        VecT vd;
    } RespT;

endpackage

// File: rtl/xadac_if.sv
// Request/response channel between an xadac initiator and one execution unit.
interface xadac_if;
    import xadac_pkg::*;

    logic req_valid;
    logic req_ready;
    IdT   req_id;
    RegT  req_rs1;
    ImmT  req_imm;
    logic resp_valid;
    logic resp_ready;
    IdT   resp_id;
    RegT  resp_rd;
    VecT  resp_vd;

    modport mst (
        output req_valid, req_id, req_rs1, req_imm, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_rd, resp_vd
    );

    modport slv (
        input  req_valid, req_id, req_rs1, req_imm, resp_ready,
        output req_ready, resp_valid, resp_id, resp_rd, resp_vd
    );
endinterface

// File: rtl/xadac_fifo.sv
// Small synchronous FIFO with registered storage; the head is read straight from the storage flops.
module xadac_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic push_valid,
    output logic push_ready,
    input  T     push_data,
    output logic pop_valid,
    input  logic pop_ready,
    output T     pop_data
);
    localparam int unsigned     PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned     CntW    = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    T                mem_q [Depth];
    T                mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            push_fire;
    logic            pop_fire;

    assign pop_valid  = (cnt_q != '0);
    assign push_ready = (cnt_q != FullCnt);
    assign pop_data   = mem_q[rd_ptr_q];
    assign pop_fire   = pop_valid && pop_ready;
    // a full FIFO still takes a write when its head leaves in the same cycle
    assign push_fire  = push_valid && (push_ready || pop_fire);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_fire) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_fire) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push_fire && !pop_fire) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_fire && pop_fire) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/xadac_issue_ctrl.sv
// xadac initiator: issues offload commands in order, tracks outstanding IDs with a credit
// counter and an ID FIFO, checks response IDs and buffers results toward writeback.
module xadac_issue_ctrl
    import xadac_pkg::*;
#(
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned RespDepth      = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic cmd_valid,
    output logic cmd_ready,
    input  IdT   cmd_id,
    input  RegT  cmd_rs1,
    input  ImmT  cmd_imm,
    xadac_if.mst mst,
    output logic out_valid,
    input  logic out_ready,
    output IdT   out_id,
    output RegT  out_rd,
    output VecT  out_vd,
    output logic err_id,
    output logic busy
);
    localparam int unsigned        CreditW   = $clog2(MaxOutstanding) + 1;
    localparam logic [CreditW-1:0] CreditMax = CreditW'(MaxOutstanding);

    if (RespDepth < MaxOutstanding) begin : g_bad_resp_depth
        $error("xadac_issue_ctrl: RespDepth must be >= MaxOutstanding");
    end
    if ((MaxOutstanding == 0) || ((MaxOutstanding & (MaxOutstanding - 1)) != 0)) begin : g_bad_max_out
        $error("xadac_issue_ctrl: MaxOutstanding must be a power of two");
    end

    logic               req_valid_q, req_valid_d;
    IdT                 req_id_q, req_id_d;
    RegT                req_rs1_q, req_rs1_d;
    ImmT                req_imm_q, req_imm_d;
    logic [CreditW-1:0] credit_q, credit_d;
    logic               err_q, err_d;

    logic cmd_fire, req_fire, resp_fire, out_fire;
    logic id_push, id_pop, id_nonempty, id_avail, unused_id_ready;
    IdT   id_fifo_head, id_head;
    logic resp_push, resp_not_full;
    RespT resp_in, resp_head;

    assign req_fire  = req_valid_q && mst.req_ready;
    assign resp_fire = mst.resp_valid && mst.resp_ready;
    assign out_fire  = out_valid && out_ready;
    assign cmd_ready = (!req_valid_q || req_fire) && (credit_q < CreditMax);
    assign cmd_fire  = cmd_valid && cmd_ready;

    // With an empty ID FIFO, a request issuing this cycle acts as the head so a
    // combinational slave's same-cycle response is matched, not flagged spurious.
    assign id_head  = id_nonempty ? id_fifo_head : req_id_q;
    assign id_avail = id_nonempty || req_fire;
    assign id_push  = req_fire && !(resp_fire && !id_nonempty);
    assign id_pop   = resp_fire && id_nonempty;

    assign resp_push      = resp_fire && id_avail;
    assign resp_in        = '{id: mst.resp_id, rd: mst.resp_rd, vd: mst.resp_vd};
    assign mst.resp_ready = resp_not_full;

    assign mst.req_valid = req_valid_q;
    assign mst.req_id    = req_id_q;
    assign mst.req_rs1   = req_rs1_q;
    assign mst.req_imm   = req_imm_q;

    assign out_id = resp_head.id;
    assign out_rd = resp_head.rd;
    assign out_vd = resp_head.vd;
    assign err_id = err_q;
    assign busy   = (credit_q != '0) || req_valid_q;

    always_comb begin
        req_valid_d = req_valid_q;
        req_id_d    = req_id_q;
        req_rs1_d   = req_rs1_q;
        req_imm_d   = req_imm_q;
        credit_d    = credit_q;
        if (cmd_fire) begin
            req_valid_d = 1'b1;
            req_id_d    = cmd_id;
            req_rs1_d   = cmd_rs1;
            req_imm_d   = cmd_imm;
        end else if (req_fire) begin
            req_valid_d = 1'b0;
        end
        if (cmd_fire && !out_fire) begin
            credit_d = credit_q + 1'b1;
        end else if (!cmd_fire && out_fire) begin
            credit_d = credit_q - 1'b1;
        end
        err_d = err_q || (resp_fire && (!id_avail || (mst.resp_id != id_head)));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_valid_q <= 1'b0;
            req_id_q    <= '0;
            req_rs1_q   <= '0;
            req_imm_q   <= '0;
            credit_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            req_valid_q <= req_valid_d;
            req_id_q    <= req_id_d;
            req_rs1_q   <= req_rs1_d;
            req_imm_q   <= req_imm_d;
            credit_q    <= credit_d;
            err_q       <= err_d;
        end
    end

    xadac_fifo #(
        .T     (IdT),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_valid (id_push),
        .push_ready (unused_id_ready),
        .push_data  (req_id_q),
        .pop_valid  (id_nonempty),
        .pop_ready  (id_pop),
        .pop_data   (id_fifo_head)
    );

    xadac_fifo #(
        .T     (RespT),
        .Depth (RespDepth)
    ) u_resp_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push_valid (resp_push),
        .push_ready (resp_not_full),
        .push_data  (resp_in),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (resp_head)
    );
endmodule
